updi_target_responder: RTL and testbench
========================================

UPDI_TARGET_RESPONDER -- requirements
Module: updi_target_responder

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CLKS, default 50000, giving the maximum idle clocks between bytes inside a frame.
REQ-002 The module SHALL have parameter UPDI_REV, default 4'h3, returned in STATUSA[7:4].
REQ-003 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port uart_rx_fifo_data_out, input, 8 bits: first-word-fall-through RX FIFO head byte, valid while empty=0.
REQ-006 Port uart_rx_fifo_rd_en, output, 1 bit: pops the RX head byte for one cycle.
REQ-007 Port uart_rx_fifo_empty, input, 1 bit: the RX FIFO is empty.
REQ-008 Port uart_tx_fifo_data_in, output, 8 bits: response byte.
REQ-009 Port uart_tx_fifo_wr_en, output, 1 bit: pushes the response byte for one cycle.
REQ-010 Port uart_tx_fifo_full, input, 1 bit: the TX FIFO is full.
REQ-011 Port break_detected, input, 1 bit: one-cycle pulse from the PHY on a received BREAK.
REQ-012 Port phy_error, input, 1 bit: one-cycle pulse on an RX parity or framing error.
REQ-013 The memory interface SHALL be these five ports:
- mem_req, output, 1 bit
- mem_we, output, 1 bit
- mem_addr, output, 16 bits
- mem_wdata, output, 8 bits
- mem_rdata, input, 8 bits
REQ-014 Port mem_ack, input, 1 bit: completes the outstanding request; mem_rdata is valid in the same cycle.
REQ-015 Port proto_error, output, 1 bit: sticky protocol-error flag.
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 States SHALL be IDLE, OPCODE, CS_DATA, ADDR_LO, ADDR_HI, MEM_ACC, WDATA and TX; TX returns to a stored next state.
REQ-018 Byte consume rule: rd_en=1 only when empty=0 and the state expects a byte; the byte is sampled in that cycle.
REQ-019 Byte push rule: wr_en=1 only when full=0; a full FIFO holds TX with data_in stable.
REQ-020 Framing:
- IDLE: consumes and discards every byte except 0x55 (SYNCH).
- 0x55 in IDLE -> OPCODE.
REQ-021 Opcode 0x80|a (LDCS): send CS[a] -> IDLE.
REQ-022 Opcode 0xC0|a (STCS): next byte written to CS[a] -> IDLE; no response byte.
REQ-023 Opcode 0x04 (LDS, 16-bit address, byte data):
- ADDR_LO, then ADDR_HI.
- MEM_ACC read.
- Send mem_rdata -> IDLE.
REQ-024 Opcode 0x44 (STS, 16-bit address, byte data):
- Address bytes, then send ACK 0x40.
- WDATA, then MEM_ACC write.
- Send ACK 0x40 -> IDLE.
REQ-025 Any other opcode SHALL set proto_error and go to IDLE with no response.
REQ-026 Memory handshake:
- mem_req is held high from MEM_ACC entry until the mem_ack cycle inclusive.
- mem_we, mem_addr and mem_wdata are stable throughout.
- mem_ack outside MEM_ACC is ignored.
REQ-027 CS register file: 16 x 8 bits.
- CS[0] (STATUSA) reads {UPDI_REV,4'h0}; writes to it are ignored.
- CS[1..15] are read/write.
REQ-028 Inter-byte timeout:
- A counter clears on every consumed byte.
- It counts in states awaiting RX (excluding IDLE).
- Reaching TIMEOUT_CLKS sets proto_error -> IDLE.
REQ-029 phy_error in any non-IDLE state SHALL abort to IDLE and set proto_error; in IDLE it is ignored.
REQ-030 break_detected SHALL have priority over all events in the same cycle:
- -> IDLE, proto_error=0, mem_req=0.
- CS contents are kept.
- Any pending TX byte is dropped.
REQ-031 A break during MEM_ACC abandons the access; a later mem_ack is ignored.
REQ-032 Latency:
- From consuming the final request byte to wr_en, at most 2 clocks, excluding memory wait and FIFO full.
- For STCS, the CS write lands the cycle after the data byte is consumed.

Reset
REQ-033 While rst_n=0, the module SHALL hold:
- state IDLE
- all FIFO and memory strobes 0
- mem_addr 0, mem_wdata 0
- proto_error 0, busy 0
- CS[1..15] = 0x00, timeout counter 0
REQ-034 Deassertion of rst_n SHALL be usable asynchronously; the first byte consumption is allowed on the first clock edge after release.

Verification
REQ-035 Bytes 0x55, 0x80 -> exactly one TX byte, 0x30 (UPDI_REV=3); proto_error=0.
REQ-036 Bytes 0x55,0xC3,0xA5 then 0x55,0x83 -> TX byte 0xA5.
REQ-037 Bytes 0x55,0x44,0x34,0x12,[wait ACK],0x5A -> response sequence:
- TX 0x40.
- mem_req with we=1, addr 0x1234, wdata 0x5A.
- After mem_ack, TX 0x40.
REQ-038 Bytes 0x55,0x04,0x00,0x80 with mem_rdata=0x77 and mem_ack after 3 clocks -> TX 0x77; uart_tx_fifo_full held high 5 clocks -> data_in stays 0x77 until pushed.
REQ-039 Bytes 0x55,0x04,0x00 then silence for TIMEOUT_CLKS -> proto_error=1, IDLE; then break_detected -> proto_error=0.
REQ-040 Opcode 0x24 -> proto_error=1, no TX; break_detected asserted mid-MEM_ACC -> mem_req drops next cycle and the late mem_ack produces no TX.

Source files
------------

// File: rtl/updi_target_responder_if.sv
// Memory-side bus of the UPDI target responder.
//   mem_req   : request strobe, held until the mem_ack cycle inclusive
//   mem_we    : 1 = write, 0 = read (stable while mem_req is high)
//   mem_addr  : 16-bit byte address (stable while mem_req is high)
//   mem_wdata : write data (stable while mem_req is high)
//   mem_rdata : read data, valid in the mem_ack cycle
//   mem_ack   : completes the outstanding request
// master = responder side, slave = memory side.
interface updi_target_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/updi_target_responder.sv
// UPDI target-side instruction responder.
// Parses SYNCH-framed UPDI instructions from a first-word-fall-through RX FIFO
// (LDCS, STCS, LDS, STS with 16-bit address / byte data), accesses a 16x8
// control/status register file or an external memory bus, and pushes response
// bytes into a TX FIFO.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   uart_rx_fifo_data_out/_empty/_rd_en : RX FIFO head, empty flag, pop strobe
//   uart_tx_fifo_data_in/_full/_wr_en   : TX response byte, full flag, push strobe
//   break_detected, phy_error  : one-cycle PHY event pulses
//   mem                        : memory bus (master modport)
//   proto_error                : sticky protocol error, cleared by BREAK
//   busy                       : state is not IDLE
module updi_target_responder #(
  parameter int unsigned TIMEOUT_CLKS = 50000,
  parameter logic [3:0]  UPDI_REV     = 4'h3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     uart_rx_fifo_data_out,
  output logic                           uart_rx_fifo_rd_en,
  input  logic                           uart_rx_fifo_empty,
  output logic [7:0]                     uart_tx_fifo_data_in,
  output logic                           uart_tx_fifo_wr_en,
  input  logic                           uart_tx_fifo_full,
  input  logic                           break_detected,
  input  logic                           phy_error,
  updi_target_responder_if.master        mem,
  output logic                           proto_error,
  output logic                           busy
);

  localparam int unsigned TW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] SYNCH = 8'h55;
  localparam logic [7:0] ACK   = 8'h40;

  typedef enum logic [2:0] {
    IDLE, OPCODE, CS_DATA, ADDR_LO, ADDR_HI, MEM_ACC, WDATA, TX
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic            we_q, we_d;
  logic            req_q, req_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [3:0]      idx_q, idx_d;
  logic            err_q, err_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [7:0]      cs_q [16];
  logic [7:0]      cs_d [16];
  logic            rx_state;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    we_d      = we_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_byte_d = tx_byte_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cnt_d     = '0;
    cs_d      = cs_q;
    uart_rx_fifo_rd_en = 1'b0;
    uart_tx_fifo_wr_en = 1'b0;
    rx_state  = state_q inside {IDLE, OPCODE, CS_DATA, ADDR_LO, ADDR_HI, WDATA};

    if (break_detected) begin
      // BREAK outranks everything: any pending TX byte and memory access die here.
      state_d = IDLE;
      err_d   = 1'b0;
      req_d   = 1'b0;
    end else if (phy_error && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = 1'b1;
      req_d   = 1'b0;
    end else begin
      uart_rx_fifo_rd_en = rst_n && rx_state && !uart_rx_fifo_empty;
      case (state_q)
        IDLE: begin
          if (uart_rx_fifo_rd_en && uart_rx_fifo_data_out == SYNCH) state_d = OPCODE;
        end
        OPCODE: begin
          if (uart_rx_fifo_rd_en) begin
            if (uart_rx_fifo_data_out[7:4] == 4'h8) begin
              tx_byte_d = (uart_rx_fifo_data_out[3:0] == 4'h0) ? {UPDI_REV, 4'h0}
                                                                : cs_q[uart_rx_fifo_data_out[3:0]];
              ret_d     = IDLE;
              state_d   = TX;
            end else if (uart_rx_fifo_data_out[7:4] == 4'hC) begin
              idx_d   = uart_rx_fifo_data_out[3:0];
              state_d = CS_DATA;
            end else if (uart_rx_fifo_data_out == 8'h04) begin
              we_d    = 1'b0;
              state_d = ADDR_LO;
            end else if (uart_rx_fifo_data_out == 8'h44) begin
              we_d    = 1'b1;
              state_d = ADDR_LO;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        CS_DATA: begin
          if (uart_rx_fifo_rd_en) begin
            // STATUSA is read-only; its read value is synthesised, not stored.
            if (idx_q != 4'h0) cs_d[idx_q] = uart_rx_fifo_data_out;
            state_d = IDLE;
          end
        end
        ADDR_LO: begin
          if (uart_rx_fifo_rd_en) begin
            addr_d[7:0] = uart_rx_fifo_data_out;
            state_d     = ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (uart_rx_fifo_rd_en) begin
            addr_d[15:8] = uart_rx_fifo_data_out;
            if (we_q) begin
              tx_byte_d = ACK;
              ret_d     = WDATA;
              state_d   = TX;
            end else begin
              req_d   = 1'b1;
              state_d = MEM_ACC;
            end
          end
        end
        WDATA: begin
          if (uart_rx_fifo_rd_en) begin
            wdata_d = uart_rx_fifo_data_out;
            req_d   = 1'b1;
            state_d = MEM_ACC;
          end
        end
        MEM_ACC: begin
          if (mem.mem_ack) begin
            req_d     = 1'b0;
            tx_byte_d = we_q ? ACK : mem.mem_rdata;
            ret_d     = IDLE;
            state_d   = TX;
          end
        end
        TX: begin
          uart_tx_fifo_wr_en = rst_n && !uart_tx_fifo_full;
          if (!uart_tx_fifo_full) state_d = ret_q;
        end
        default: state_d = IDLE;
      endcase

      // Inter-byte timeout: only while waiting for a byte inside a frame.
      if (rx_state && state_q != IDLE && !uart_rx_fifo_rd_en) begin
        if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_byte_q <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < 16; i++) cs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      we_q      <= we_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_byte_q <= tx_byte_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
    end
  end

  assign uart_tx_fifo_data_in = tx_byte_q;
  assign mem.mem_req          = req_q;
  assign mem.mem_we           = we_q;
  assign mem.mem_addr         = addr_q;
  assign mem.mem_wdata        = wdata_q;
  assign proto_error          = err_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_updi_target_responder.sv
module tb_updi_target_responder;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rd_en;
  logic       rx_empty;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_full;
  logic       brk = 1'b0;
  logic       perr = 1'b0;
  logic       proto_error;
  logic       busy;

  always #5 clk = ~clk;

  updi_target_responder_if mif ();

  updi_target_responder #(.TIMEOUT_CLKS(TO), .UPDI_REV(4'h3)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .uart_rx_fifo_data_out (rx_data),
    .uart_rx_fifo_rd_en    (rx_rd_en),
    .uart_rx_fifo_empty    (rx_empty),
    .uart_tx_fifo_data_in  (tx_data),
    .uart_tx_fifo_wr_en    (tx_wr_en),
    .uart_tx_fifo_full     (tx_full),
    .break_detected        (brk),
    .phy_error             (perr),
    .mem                   (mif),
    .proto_error           (proto_error),
    .busy                  (busy)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_op_t;

  int          tests = 0;
  int          fails = 0;
  int          tx_seen = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  mem_op_t     exp_mem[$];
  bit          rand_full_en = 0;
  bit          force_full = 0;
  int unsigned mem_delay = 0;
  logic [7:0]  resp_mem [int];
  logic [7:0]  ref_mem [int];
  logic [7:0]  cs_ref [16];
  bit          err_ref = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic bit valid_op(input logic [7:0] op);
    return (op[7:4] == 4'h8) || (op[7:4] == 4'hC) || (op == 8'h04) || (op == 8'h44);
  endfunction

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  // RX FIFO model (first-word-fall-through)
  initial begin
    bit pop;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      pop = rx_rd_en;
      @(posedge clk);
      #1;
      if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 8'($urandom) : rx_q[0];
    end
  end

  // TX FIFO full flag
  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_full = rand_full_en ? ($urandom_range(0, 3) == 0) : force_full;
    end
  end

  // Memory responder with programmable latency
  initial begin
    bit          pend;
    int unsigned cnt;
    logic        p_we;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;
    pend = 0;
    cnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!pend && mif.mem_req && !mif.mem_ack) begin
        pend    = 1;
        cnt     = mem_delay;
        p_we    = mif.mem_we;
        p_addr  = mif.mem_addr;
        p_wdata = mif.mem_wdata;
      end
      @(posedge clk);
      #1;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 8'($urandom);
      if (pend) begin
        if (cnt == 0) begin
          mif.mem_ack = 1'b1;
          pend = 0;
          if (p_we) resp_mem[int'(p_addr)] = p_wdata;
          else mif.mem_rdata = resp_mem.exists(int'(p_addr)) ? resp_mem[int'(p_addr)] : init_val(p_addr);
        end else begin
          cnt--;
        end
      end
    end
  end

  // Per-cycle comparison against the expected response/memory streams
  initial begin
    bit      prev_req;
    bit      have_cur;
    mem_op_t cur;
    prev_req = 0;
    have_cur = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_empty) chk("rd_en_while_empty", rx_rd_en, 1'b0);
        if (tx_full)  chk("wr_en_while_full", tx_wr_en, 1'b0);
        if (tx_wr_en) begin
          tx_seen++;
          if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", tx_data);
          end else begin
            chk("tx_byte", tx_data, exp_tx.pop_front());
          end
        end
        if (mif.mem_req && !prev_req) begin
          if (exp_mem.size() == 0) begin
            tests++;
            fails++;
            have_cur = 0;
            $display("FAIL mem_unexpected: got req addr 0x%0h we %0d, expected no request", mif.mem_addr, mif.mem_we);
          end else begin
            cur = exp_mem.pop_front();
            have_cur = 1;
          end
        end
        if (mif.mem_req && have_cur) begin
          chk("mem_we", mif.mem_we, cur.we);
          chk("mem_addr", mif.mem_addr, cur.addr);
          if (cur.we) chk("mem_wdata", mif.mem_wdata, cur.wdata);
        end
        prev_req = mif.mem_req;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 3000 && !(rx_q.size() == 0 && exp_tx.size() == 0 && exp_mem.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s: not idle in time, busy=%0d pending_tx=%0d pending_mem=%0d, expected idle",
               name, busy, exp_tx.size(), exp_mem.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (n < 200 && rx_q.size() != 0) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s: rx bytes left %0d, expected 0", name, rx_q.size());
    end
  endtask

  task automatic pulse_break();
    @(posedge clk); #1; brk = 1'b1;
    @(posedge clk); #1; brk = 1'b0;
    err_ref = 0;
  endtask

  task automatic pulse_perr();
    @(posedge clk); #1; perr = 1'b1;
    @(posedge clk); #1; perr = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [8];
    int          t0;
    int          n;
    for (int i = 0; i < 16; i++) cs_ref[i] = 8'h00;

    // Reset: a garbage byte sits in the FIFO; nothing may be popped.
    push(8'h00);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rx_rd_en, 1'b0);
    chk("rst_wr_en", tx_wr_en, 1'b0);
    chk("rst_mem_req", mif.mem_req, 1'b0);
    chk("rst_mem_we", mif.mem_we, 1'b0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_mem_wdata", mif.mem_wdata, 8'h00);
    chk("rst_proto_error", proto_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_idle("reset_drain");

    // LDCS STATUSA
    push(8'h55); push(8'h80);
    exp_tx.push_back(8'h30);
    wait_idle("ldcs0");
    chk("ldcs0_proto_error", proto_error, 1'b0);

    // STCS CS[3] then LDCS CS[3]
    push(8'h55); push(8'hC3); push(8'hA5); push(8'h55); push(8'h83);
    cs_ref[3] = 8'hA5;
    exp_tx.push_back(8'hA5);
    wait_idle("stcs3_ldcs3");

    // STATUSA is read-only
    push(8'h55); push(8'hC0); push(8'hFF); push(8'h55); push(8'h80);
    exp_tx.push_back(8'h30);
    wait_idle("statusa_ro");

    // STS 0x1234 <- 0x5A, waiting for the address ACK before sending data
    mem_delay = 1;
    t0 = tx_seen;
    exp_tx.push_back(8'h40);
    push(8'h55); push(8'h44); push(8'h34); push(8'h12);
    n = 0;
    while (n < 100 && tx_seen == t0) begin @(negedge clk); n++; end
    chk("sts_addr_ack_seen", (tx_seen > t0), 1'b1);
    exp_mem.push_back('{we: 1'b1, addr: 16'h1234, wdata: 8'h5A});
    exp_tx.push_back(8'h40);
    ref_mem[32'h1234] = 8'h5A;
    push(8'h5A);
    wait_idle("sts_1234");

    // LDS 0x1234 reads back the stored byte
    push(8'h55); push(8'h04); push(8'h34); push(8'h12);
    exp_mem.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'h00});
    exp_tx.push_back(8'h5A);
    wait_idle("lds_1234");

    // LDS 0x8000 = 0x77, ack 3 clocks after request, TX FIFO full for 5 clocks
    resp_mem[32'h8000] = 8'h77;
    ref_mem[32'h8000]  = 8'h77;
    mem_delay = 2;
    force_full = 1;
    exp_mem.push_back('{we: 1'b0, addr: 16'h8000, wdata: 8'h00});
    exp_tx.push_back(8'h77);
    push(8'h55); push(8'h04); push(8'h00); push(8'h80);
    n = 0;
    while (n < 100 && !mif.mem_ack) begin @(negedge clk); n++; end
    chk("lds_8000_ack_seen", mif.mem_ack, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_hold_data", tx_data, 8'h77);
      chk("full_hold_busy", busy, 1'b1);
    end
    force_full = 0;
    wait_idle("lds_8000_full");

    // Gap shorter than the timeout is tolerated
    push(8'h55); push(8'h04);
    wait_drained("short_gap_drain");
    repeat (12) @(negedge clk);
    chk("short_gap_proto_error", proto_error, 1'b0);
    exp_mem.push_back('{we: 1'b0, addr: 16'h8000, wdata: 8'h00});
    exp_tx.push_back(8'h77);
    push(8'h00); push(8'h80);
    wait_idle("short_gap");
    chk("short_gap_proto_error_end", proto_error, 1'b0);

    // Inter-byte timeout, then BREAK clears the error
    push(8'h55); push(8'h04); push(8'h00);
    wait_drained("timeout_drain");
    repeat (10) @(negedge clk);
    chk("timeout_early_proto_error", proto_error, 1'b0);
    chk("timeout_early_busy", busy, 1'b1);
    repeat (15) @(negedge clk);
    chk("timeout_proto_error", proto_error, 1'b1);
    chk("timeout_busy", busy, 1'b0);
    pulse_break();
    @(negedge clk);
    chk("break_clears_error", proto_error, 1'b0);

    // phy_error aborts a frame; ignored in IDLE
    push(8'h55); push(8'hC5);
    wait_drained("perr_drain");
    pulse_perr();
    @(negedge clk);
    chk("perr_proto_error", proto_error, 1'b1);
    chk("perr_busy", busy, 1'b0);
    pulse_break();
    pulse_perr();
    @(negedge clk);
    chk("perr_idle_proto_error", proto_error, 1'b0);

    // CS contents survive BREAK
    push(8'h55); push(8'h83);
    exp_tx.push_back(8'hA5);
    wait_idle("cs_after_break");

    // Illegal opcode
    push(8'h55); push(8'h24);
    wait_idle("bad_opcode");
    chk("bad_opcode_proto_error", proto_error, 1'b1);
    pulse_break();

    // BREAK during MEM_ACC: request drops, late ack is ignored
    mem_delay = 6;
    t0 = tx_seen;
    exp_mem.push_back('{we: 1'b0, addr: 16'h2010, wdata: 8'h00});
    push(8'h55); push(8'h04); push(8'h10); push(8'h20);
    n = 0;
    while (n < 100 && !mif.mem_req) begin @(negedge clk); n++; end
    chk("brk_mem_req_seen", mif.mem_req, 1'b1);
    pulse_break();
    @(negedge clk);
    chk("brk_mem_req_drop", mif.mem_req, 1'b0);
    chk("brk_busy", busy, 1'b0);
    repeat (12) @(negedge clk);
    chk("brk_late_ack_no_tx", tx_seen, t0);
    chk("brk_proto_error", proto_error, 1'b0);

    // Randomized frames
    pool[0] = 16'h1234; pool[1] = 16'h8000; pool[2] = 16'h0000; pool[3] = 16'hFFFF;
    for (int i = 4; i < 8; i++) pool[i] = 16'($urandom);
    rand_full_en = 1;
    for (int f = 0; f < 200; f++) begin
      int unsigned kind;
      logic [7:0]  a;
      logic [7:0]  d;
      logic [7:0]  g;
      logic [15:0] ad;
      kind = $urandom_range(0, 5);
      mem_delay = $urandom_range(0, 4);
      if (kind == 5) begin
        pulse_break();
      end else begin
        for (int j = $urandom_range(0, 2); j > 0; j--) begin
          do g = 8'($urandom); while (g == 8'h55);
          push(g);
        end
        push(8'h55);
        a  = 8'($urandom_range(0, 15));
        d  = 8'($urandom);
        ad = pool[$urandom_range(0, 7)];
        case (kind)
          0: begin
            push(8'h80 | a);
            exp_tx.push_back((a == 0) ? 8'h30 : cs_ref[a[3:0]]);
          end
          1: begin
            push(8'hC0 | a); push(d);
            if (a != 0) cs_ref[a[3:0]] = d;
          end
          2: begin
            push(8'h04); push(ad[7:0]); push(ad[15:8]);
            exp_mem.push_back('{we: 1'b0, addr: ad, wdata: 8'h00});
            exp_tx.push_back(ref_read(ad));
          end
          3: begin
            push(8'h44); push(ad[7:0]); push(ad[15:8]); push(d);
            exp_tx.push_back(8'h40);
            exp_mem.push_back('{we: 1'b1, addr: ad, wdata: d});
            exp_tx.push_back(8'h40);
            ref_mem[int'(ad)] = d;
          end
          default: begin
            do g = 8'($urandom); while (valid_op(g));
            push(g);
            err_ref = 1;
          end
        endcase
      end
      wait_idle("rand_frame");
      chk("rand_proto_error", proto_error, err_ref);
    end
    rand_full_en = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
